// File: rtl/matdet_seq.sv
// Sequencer for the matdetN determinant cores: gathers a row-major element stream, runs the core
// restart/complete handshake and emits the determinant. Optional MATDET_SEQ_STATS_EN adds counters.
//
// state   | meaning
// S_LOAD  | accepting elements into the matrix slots
// S_START | core_rst held high, waiting for core_ready
// S_RUN   | waiting for a qualified core_complete
// S_OUT   | determinant presented until out_ready
module matdet_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int BIN_POS     = 8,
  parameter int MATRIX_SIZE = 3
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      in_valid_i,
  output logic                                      in_ready_o,
  input  logic [DATA_WIDTH-1:0]                     in_data_i,
  output logic                                      core_rst_o,
  input  logic                                      core_ready_i,
  input  logic                                      core_complete_i,
  output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] core_matrix_o,
  input  logic [DATA_WIDTH-1:0]                     core_det_i,
  output logic                                      out_valid_o,
  input  logic                                      out_ready_i,
  output logic [DATA_WIDTH-1:0]                     out_det_o,
`ifdef MATDET_SEQ_STATS_EN
  output logic [31:0]                               stat_count_o,
  output logic [31:0]                               stat_cycles_o,
`endif
  output logic                                      busy_o
);

  localparam int NELEM = MATRIX_SIZE * MATRIX_SIZE;
  localparam int MW    = NELEM * DATA_WIDTH;
  localparam int CW    = (NELEM > 1) ? $clog2(NELEM) : 1;
  localparam logic [CW-1:0] LAST = CW'(NELEM - 1);

  // The binary point is only carried through; reject nonsensical values at elaboration.
  if (BIN_POS < 0 || BIN_POS > DATA_WIDTH) begin : g_bad_bin_pos
    $error("matdet_seq: BIN_POS out of range");
  end

  typedef enum logic [1:0] {S_LOAD, S_START, S_RUN, S_OUT} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [MW-1:0]         matrix_q, matrix_d;
  logic                  core_rst_q, core_rst_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_det_q, out_det_d;
  logic                  take_result, out_hs;

  // A complete that arrives while restart is still asserted belongs to the previous job.
  assign take_result = (state_q == S_RUN) && core_complete_i && !core_rst_q;
  assign out_hs      = out_valid_q && out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_LOAD;
      count_q     <= '0;
      matrix_q    <= '0;
      core_rst_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_det_q   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      matrix_q    <= matrix_d;
      core_rst_q  <= core_rst_d;
      out_valid_q <= out_valid_d;
      out_det_q   <= out_det_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    matrix_d    = matrix_q;
    core_rst_d  = core_rst_q;
    out_valid_d = out_valid_q;
    out_det_d   = out_det_q;
    unique case (state_q)
      S_LOAD: begin
        if (in_valid_i) begin
          for (int k = 0; k < NELEM; k++) begin
            if (count_q == CW'(k)) matrix_d[k*DATA_WIDTH +: DATA_WIDTH] = in_data_i;
          end
          if (count_q == LAST) begin
            count_d    = '0;
            state_d    = S_START;
            core_rst_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      S_START: begin
        if (core_ready_i) begin
          core_rst_d = 1'b0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (take_result) begin
          out_valid_d = 1'b1;
          out_det_d   = core_det_i;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          state_d     = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign in_ready_o    = (state_q == S_LOAD);
  assign core_rst_o    = core_rst_q;
  assign core_matrix_o = matrix_q;
  assign out_valid_o   = out_valid_q;
  assign out_det_o     = out_det_q;
  assign busy_o        = !((state_q == S_LOAD) && (count_q == '0));

`ifdef MATDET_SEQ_STATS_EN
  logic [31:0] cyc_q, stat_count_q, stat_cycles_q;

  // cyc_q restarts in LOAD so it counts START+RUN cycles of the current job.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q         <= '0;
      stat_count_q  <= '0;
      stat_cycles_q <= '0;
    end else begin
      if (state_q == S_LOAD) cyc_q <= '0;
      else                   cyc_q <= cyc_q + 32'd1;
      if (take_result) stat_cycles_q <= cyc_q + 32'd1;
      if (out_hs)      stat_count_q  <= stat_count_q + 32'd1;
    end
  end

  assign stat_count_o  = stat_count_q;
  assign stat_cycles_o = stat_cycles_q;
`endif

endmodule

// File: tb/tb_matdet_seq.sv
// Self-checking bench for matdet_seq: transaction-level reference model, a reactive core model
// and directed element streams with hand-computed expectations.
module tb_matdet_seq;
  localparam int DW = 16;
  localparam int N  = 3;
  localparam int NE = N * N;
  localparam int MW = NE * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          core_rst;
  logic          core_ready = 1'b0;
  logic          core_complete = 1'b0;
  logic [MW-1:0] core_matrix;
  logic [DW-1:0] core_det = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_det;
  logic          busy;
`ifdef MATDET_SEQ_STATS_EN
  logic [31:0]   stat_count, stat_cycles;
`endif

  always #5 clk = ~clk;

  matdet_seq #(.DATA_WIDTH(DW), .BIN_POS(8), .MATRIX_SIZE(N)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .core_rst_o(core_rst), .core_ready_i(core_ready), .core_complete_i(core_complete),
    .core_matrix_o(core_matrix), .core_det_i(core_det),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_det_o(out_det),
`ifdef MATDET_SEQ_STATS_EN
    .stat_count_o(stat_count), .stat_cycles_o(stat_cycles),
`endif
    .busy_o(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a job is the list of accepted elements; it is handed to the core once
  // full, acknowledged by core_ready, answered by core_complete, and retired on out handshake.
  logic [DW-1:0] elems[$];
  logic [DW-1:0] m_mat[NE];
  bit            granted = 0;
  bit            held = 0;
  logic [DW-1:0] e_det = '0;

  initial begin
    for (int k = 0; k < NE; k++) m_mat[k] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        elems.delete();
        granted = 0;
        held = 0;
        e_det = '0;
        for (int k = 0; k < NE; k++) m_mat[k] = '0;
      end else if (elems.size() < NE) begin
        if (in_valid) begin
          m_mat[elems.size()] = in_data;
          elems.push_back(in_data);
        end
      end else if (!granted) begin
        if (core_ready) granted = 1;
      end else if (!held) begin
        if (core_complete) begin
          held = 1;
          e_det = core_det;
        end
      end else if (out_ready) begin
        elems.delete();
        granted = 0;
        held = 0;
      end
    end
  end

  logic [DW-1:0] got[$];

  initial begin
    logic [MW-1:0] pk;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NE; k++) pk[k*DW +: DW] = m_mat[k];
      chk("in_ready", in_ready, elems.size() < NE);
      chk("core_rst", core_rst, (elems.size() == NE) && !granted);
      chk("out_valid", out_valid, held);
      chk("out_det", out_det, e_det);
      chk("busy", busy, elems.size() != 0);
      chk("core_matrix", core_matrix, pk);
      if (out_valid && out_ready) got.push_back(out_det);
    end
  end

  // Core model: ready 2 cycles after restart, complete 5 cycles after restart is released.
  logic [DW-1:0] dets[8] = '{16'hFD00, 16'h1234, 16'h0A01, 16'h0B02,
                             16'h0C03, 16'h0D04, 16'h0E05, 16'h0F06};
  bit stale_mode = 0;
  int cm_st = 0, cm_t = 0, cm_job = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        core_ready = 0; core_complete = 0; core_det = '0; cm_st = 0;
      end else begin
        case (cm_st)
          0: if (core_rst) begin
               cm_st = 1; cm_t = 0;
               if (stale_mode) begin core_complete = 1; core_det = 16'h7777; end
             end
          1: begin
               cm_t++;
               if (!core_rst && core_ready) begin
                 core_ready = 0; core_complete = 0; cm_st = 2; cm_t = 0;
               end else if (cm_t == 2) core_ready = 1;
             end
          default: begin
               cm_t++;
               if (cm_t == 5) begin core_complete = 1; core_det = dets[cm_job % 8]; end
               else if (cm_t == 6) begin core_complete = 0; cm_job++; cm_st = 0; end
             end
        endcase
      end
    end
  end

  task automatic send(input logic [DW-1:0] v);
    bit acc = 0;
    in_valid = 1;
    in_data = v;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
    end
    #1;
    chk("send_accept", acc, 1);
  endtask

  task automatic wait_out(input int max);
    bit seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk("wait_out_valid", seen, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_core_rst", core_rst, 0);
    chk("rst_matrix", core_matrix, 0);
    chk("rst_out_det", out_det, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // Basic job with a stalled consumer
    for (int k = 0; k < NE; k++) send(16'(16'h0100 * (k + 1)));
    chk("core_rst_latency", core_rst, 1);
    in_valid = 0;
    chk("matrix_slot0", core_matrix[15:0], 16'h0100);
    chk("matrix_slot8", core_matrix[143:128], 16'h0900);
    wait_out(60);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_det", out_det, 16'hFD00);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("handoff_valid", out_valid, 0);

    // Stale complete during START
    stale_mode = 1;
    for (int k = 0; k < NE; k++) send(16'(16'h1000 + k));
    in_valid = 0;
    wait_out(60);
    chk("stale_det", out_det, 16'h1234);
    stale_mode = 0;
    @(posedge clk); #1;

    // Back-to-back with in_valid held high throughout
    for (int m = 0; m < 3; m++)
      for (int k = 0; k < NE; k++) send(16'(16'h2000 + m * 16 + k));
    in_valid = 0;
    for (int i = 0; i < 100 && got.size() < 5; i++) @(negedge clk);
    chk("b2b_results", got.size(), 5);
`ifdef MATDET_SEQ_STATS_EN
    chk("stat_count", stat_count, 5);
`endif
    @(posedge clk); #1;

    // Reset mid-LOAD
    for (int k = 0; k < 5; k++) send(16'(16'h3000 + k));
    in_valid = 0;
    rst_n = 0;
    #2;
    chk("rstload_busy", busy, 0);
    chk("rstload_matrix", core_matrix, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int k = 0; k < NE; k++) send(16'(16'h4000 + k));
    in_valid = 0;
    chk("fresh_slot0", core_matrix[15:0], 16'h4000);
    chk("fresh_slot8", core_matrix[143:128], 16'h4008);
    wait_out(60);
    @(posedge clk); #1;

    // Reset mid-RUN
    for (int k = 0; k < NE; k++) send(16'(16'h5000 + k));
    in_valid = 0;
    for (int i = 0; i < 50 && core_rst; i++) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 0;
    #2;
    chk("rstrun_busy", busy, 0);
    chk("rstrun_core_rst", core_rst, 0);
    chk("rstrun_matrix", core_matrix, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int k = 0; k < NE; k++) send(16'(16'h6000 + k));
    in_valid = 0;
    wait_out(60);
    chk("after_rstrun_det", out_det, 16'h0E05);
    @(posedge clk); #1;

    // Gapped input with junk data on idle cycles
    for (int k = 0; k < NE; k++) begin
      send(16'(16'h7000 + k));
      in_valid = 0;
      in_data = 16'hDEAD;
      @(posedge clk); #1;
    end
    chk("gap_slot0", core_matrix[15:0], 16'h7000);
    chk("gap_slot4", core_matrix[79:64], 16'h7004);
    chk("gap_slot8", core_matrix[143:128], 16'h7008);
    wait_out(60);
    repeat (3) @(posedge clk);
    #1;

    chk("result_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("result_order", got[i], dets[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
